// File: rtl/sdr_burst_responder_if.sv
// Synchronous memory bus between the data cache (master) and the SDR-side responder (slave).
// MData is bidirectional and travels as a separate inout port next to this bundle.
interface sdr_burst_responder_if;
   logic        MStrobe;
   logic        MRW;
   logic [3:0]  MBE;
   logic [31:0] MAddress;
   logic        MGrant;
   logic        mSDR_RxD;
   logic        mSDR_TxD;
   logic        Busy;

   modport master (
      output MStrobe, MRW, MBE, MAddress,
      input  MGrant, mSDR_RxD, mSDR_TxD, Busy
   );

   modport slave (
      input  MStrobe, MRW, MBE, MAddress,
      output MGrant, mSDR_RxD, mSDR_TxD, Busy
   );
endinterface

// File: rtl/sdr_burst_responder.sv
// Memory-side responder: accepts one strobed request and runs a fixed 4-beat halfword
// burst against an internal halfword array, either returning read data or capturing writes.
module sdr_burst_responder #(
   parameter int AW     = 12,
   parameter int RD_LAT = 2,
   parameter int WR_LAT = 1,
   parameter int REC    = 1
) (
   input  logic                 Clk,
   input  logic                 Reset,
   sdr_burst_responder_if.slave bus,
   inout  wire  [31:0]          MData
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_RBURST = 3'd2;
   localparam logic [2:0] S_WBURST = 3'd3;
   localparam logic [2:0] S_REC    = 3'd4;

   localparam logic [2:0] RD_LOAD  = 3'(RD_LAT - 1);
   localparam logic [2:0] WR_LOAD  = 3'(WR_LAT - 1);
   localparam logic [2:0] REC_LOAD = 3'((REC > 0) ? (REC - 1) : 0);

   logic [2:0]    state_r;
   logic [2:0]    state_nxt_s;
   logic [2:0]    lat_r;
   logic [2:0]    lat_nxt_s;
   logic [1:0]    beat_r;
   logic [1:0]    beat_nxt_s;
   logic [AW-1:0] base_r;
   logic          read_r;
   logic          grant_r;
   logic          rxd_r;
   logic          txd_r;
   logic          busy_r;
   logic [AW-1:0] beat_addr_s;
   logic          unused_bits;
   logic [15:0]   mem [2**AW];

   // base is 4-aligned, so the beat index simply fills the two low address bits
   assign beat_addr_s = {base_r[AW-1:2], beat_r};

   // Next-state, latency/recovery countdown and beat counter
   always_comb begin
      state_nxt_s = state_r;
      lat_nxt_s   = lat_r;
      beat_nxt_s  = beat_r;
      case (state_r)
         S_IDLE: begin
            if (bus.MStrobe) begin
               state_nxt_s = S_WAIT;
               lat_nxt_s   = bus.MRW ? RD_LOAD : WR_LOAD;
               beat_nxt_s  = 2'd0;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_WAIT: begin
            if (lat_r == 3'd0) begin
               state_nxt_s = read_r ? S_RBURST : S_WBURST;
               beat_nxt_s  = 2'd0;
            end else begin
               lat_nxt_s = lat_r - 3'd1;
            end
         end
         S_RBURST, S_WBURST: begin
            beat_nxt_s = beat_r + 2'd1;
            if (beat_r == 2'd3) begin
               lat_nxt_s   = REC_LOAD;
               state_nxt_s = (REC == 0) ? S_IDLE : S_REC;
            end else begin
               state_nxt_s = state_r;
            end
         end
         S_REC: begin
            if (lat_r == 3'd0) begin
               state_nxt_s = S_IDLE;
            end else begin
               lat_nxt_s = lat_r - 3'd1;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
            lat_nxt_s   = 3'd0;
            beat_nxt_s  = 2'd0;
         end
      endcase
   end

   // State, request capture and registered bus outputs (decoded from the next state)
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r <= S_IDLE;
         lat_r   <= 3'd0;
         beat_r  <= 2'd0;
         base_r  <= {AW{1'b0}};
         read_r  <= 1'b0;
         grant_r <= 1'b0;
         rxd_r   <= 1'b0;
         txd_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         lat_r   <= lat_nxt_s;
         beat_r  <= beat_nxt_s;
         if ((state_r == S_IDLE) && bus.MStrobe) begin
            base_r <= {bus.MAddress[AW-1:2], 2'b00};
            read_r <= bus.MRW;
         end
         grant_r <= (state_nxt_s == S_WAIT) || (state_nxt_s == S_RBURST) ||
                    (state_nxt_s == S_WBURST);
         rxd_r   <= (state_nxt_s == S_RBURST);
         txd_r   <= (state_nxt_s == S_WBURST);
         busy_r  <= (state_nxt_s != S_IDLE);
      end
   end

   // Write-beat capture; the array is deliberately not reset
   always_ff @(posedge Clk) begin
      if (txd_r) begin
         mem[beat_addr_s] <= MData[15:0];
      end
   end

   assign MData = rxd_r ? {16'h0000, mem[beat_addr_s]} : 32'hzzzz_zzzz;

   assign bus.MGrant   = grant_r;
   assign bus.mSDR_RxD = rxd_r;
   assign bus.mSDR_TxD = txd_r;
   assign bus.Busy     = busy_r;

   // Byte enables, out-of-range address bits and the upper write lane carry no meaning here
   assign unused_bits = ^{bus.MBE, bus.MAddress[31:AW], bus.MAddress[1:0], MData[31:16]};
endmodule

// File: doc/sdr_burst_responder.md
Name: sdr_burst_responder

Overview:
- Memory-side responder on the synchronous memory bus driven by the data cache's refill/write-back logic.
- Accepts one strobed request and asserts MGrant.
- Runs a fixed 4-beat, 16-bit halfword burst: it returns read data with mSDR_RxD or captures write data with mSDR_TxD.
- Backed by an internal halfword array; it serves as the SDR side of the bus in simulation and on board.

Parameters:
- AW, 12, halfword address bits decoded into the internal array (depth 2^AW halfwords).
- RD_LAT, 2, cycles from MGrant rise to the first read beat (legal range 1..7).
- WR_LAT, 1, cycles from MGrant rise to the first write beat (legal range 1..7).
- REC, 1, idle recovery cycles after a burst before the next MStrobe is accepted (legal range 0..7).

Ports:
- Clk  in  1  single clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- MStrobe  in  1  request strobe from the cache, held until MGrant is seen.
- MRW  in  1  1 = read burst, 0 = write burst; sampled with MStrobe.
- MBE  in  4  byte enables; sampled and ignored (bursts are always full halfwords).
- MAddress  in  32  halfword address; bits [AW-1:0] are used and [1:0] are forced to 00.
- MGrant  out  1  request accepted; high from accept through the last beat.
- MData  inout  32  drives {16'h0, rdata} during read beats; otherwise high-Z; [15:0] is sampled on write beats.
- mSDR_RxD  out  1  read beat valid; high for exactly 4 consecutive cycles per read.
- mSDR_TxD  out  1  write beat window; high for exactly 4 consecutive cycles per write.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: MGrant=0, mSDR_RxD=0, mSDR_TxD=0, Busy=0, MData high-Z, state=IDLE, beat counter=0. Array contents are not cleared.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronously). The partial write is kept for beats already captured.
- States:
  - IDLE: on MStrobe=1, latch base = {MAddress[AW-1:2], 2'b00} and MRW, then go to WAIT. Set MGrant=1 and Busy=1 from the next cycle.
  - WAIT: load the latency counter with RD_LAT-1 or WR_LAT-1 and count down. At 0, go to RBURST or WBURST.
  - RBURST: beat counter k=0..3; mSDR_RxD=1; MData[15:0]=mem[base+k]. Array read is combinational so data is valid in the same cycle as the strobe. After k=3, go to REC.
  - WBURST: k=0..3; mSDR_TxD=1; at each rising edge while TxD=1, mem[base+k] <= MData[15:0]. After k=3, go to REC.
  - REC: MGrant=0, strobes=0, MData high-Z. Stay REC cycles, then go to IDLE. With REC=0, go straight to IDLE.
- MGrant falls in the same cycle the last beat ends. The first cycle of REC (or IDLE when REC=0) has MGrant=0.
- Address wrap: base+k uses AW-bit arithmetic. Because base is 4-aligned, k never carries out of [1:0]. Order is always 0,1,2,3 regardless of the original MAddress[1:0].
- MStrobe in any non-IDLE state is ignored and not queued. The cache holds the strobe and it is accepted on return to IDLE.
- MStrobe sampled in IDLE on the cycle the FSM enters IDLE is accepted (back-to-back requests allowed).
- MData drive enable is exactly mSDR_RxD. There is never drive overlap with the cache's write drive.
- Beat counter is 2 bits. The latency counter is 3 bits and saturates at 0.

Test Plan:
- Preload mem[0x100..0x103]=1111,2222,3333,4444; read at MAddress=0x102 with RD_LAT=2 -> MGrant rises 1 cycle after strobe; RxD high on cycles 3-6 after strobe; MData = 0x00001111, 0x00002222, 0x00003333, 0x00004444 in order.
- Write at MAddress=0x200 with WR_LAT=1 and the cache driving A0A0, B1B1, C2C2, D3D3 during TxD -> the following read of 0x200 returns the same four halfwords. mem[0x1FF] and mem[0x204] are unchanged.
- Read at AW-top address 0xFFC with AW=12 -> beats come from 0xFFC..0xFFF and there is no wrap into 0x000.
- MStrobe held continuously with MRW toggled read/write, REC=1 -> second grant exactly REC+1 cycles after the first grant falls; no request lost or duplicated.
- Reset pulse during beat 2 of a write -> MGrant, TxD, RxD and Busy drop without waiting for a clock. mem[base], mem[base+1] are updated; mem[base+2], mem[base+3] keep old values; the next strobe is serviced normally.
- MData observed high-Z in every non-RBURST cycle across a full read-write-read sequence; no X on the bus.
